shift_pattern_detector: RTL and testbench
=========================================

Name: shift_pattern_detector

Overview:
Upstream stage of the shift_detection display path. Takes a serial data switch and a bouncy push-button, and shifts one debounced bit into an 8-bit register per button press. It detects a parameterised bit pattern in the newest bits, with overlapping matches allowed, and counts the matches. It produces the 1-bit and 4-bit values that the 7-segment decoder stage consumes.

Parameters:
PATTERN_W, 4, pattern length in bits (2..8)
PATTERN, 4'b1011, pattern compared against the newest PATTERN_W bits; the MSB is the oldest bit
DB_CNT, 1000000, consecutive stable cycles required to accept a button level change (20 ms at 50 MHz); the bench uses 4
CNT_W, 4, match counter width

Ports:
clk  input  1  system clock; all logic on the rising edge
rst_n  input  1  synchronous, active-low reset
din  input  1  raw serial data switch (asynchronous)
shift_btn_n  input  1  raw push-button, active-low, bouncy (asynchronous)
shift_reg  output  8  shift register contents; bit 0 is the newest bit
last_bit  output  1  equals shift_reg[0]; drives the 1-bit display decoder
detect  output  1  high while the newest PATTERN_W bits equal PATTERN
match_cnt  output  CNT_W  number of matches since reset, modulo 2^CNT_W; drives the hex digit decoder

Behaviour:
- Reset: one clock, one synchronous active-low reset.
  - While rst_n=0 at a clock edge: shift_reg=0, last_bit=0, detect=0, match_cnt=0, valid_cnt=0, debounce counter=0, FSM=S_IDLE.
  - Both synchroniser stages reset to 1 (button released, din high).
  - Asserting reset mid-debounce aborts the press; no shift occurs.
- Synchronisers: din and shift_btn_n each pass through 2 flip-flops, giving din_s and btn_s. All logic below uses only the synchronised signals.
- Debounce FSM, 4 states, 20-bit counter db:
  - S_IDLE (released):
    - btn_s=0 -> S_DB_PRESS, db=0.
  - S_DB_PRESS:
    - btn_s=1 -> S_IDLE.
    - Otherwise, if db==DB_CNT-1 -> S_HELD, and shift_pulse=1 for exactly that one cycle.
    - Otherwise db=db+1.
  - S_HELD:
    - btn_s=1 -> S_DB_REL, db=0.
    - Holding the button for any length of time produces no further pulses.
  - S_DB_REL:
    - btn_s=0 -> S_HELD.
    - Otherwise, if db==DB_CNT-1 -> S_IDLE.
    - Otherwise db=db+1.
  - Result: exactly one shift_pulse per accepted press; the release bounce is filtered.
- Shift, on the clock edge where shift_pulse=1:
  - shift_reg <= {shift_reg[6:0], din_s}.
  - valid_cnt <= min(valid_cnt+1, 8).
- Match logic:
  - nxt is the post-shift value, i.e. {shift_reg[PATTERN_W-2:0], din_s}.
  - On a shift edge: detect <= (nxt==PATTERN) && (valid_cnt+1 >= PATTERN_W).
  - When that match term is true, match_cnt <= match_cnt+1 on the same edge. The counter wraps from 2^CNT_W-1 to 0.
  - detect is a level: it holds until the next shift edge and changes only on shift edges.
  - Matches may overlap; the register is never cleared after a match.
  - The valid_cnt guard blocks false matches against reset zeros, e.g. PATTERN=0000 cannot match until PATTERN_W real bits have been shifted in.
- Latency:
  - Raw button falling edge (stable) -> shift_pulse after 2 + DB_CNT cycles.
  - shift_reg, last_bit, detect and match_cnt are all registered and update together on the edge where shift_pulse=1.
  - din is sampled via din_s on that same edge.
- A press coinciding with a din change: the bit shifted in is whatever din_s holds on the pulse edge.

Test Plan:
1. Reset: hold rst_n=0 for 3 cycles with inputs toggling -> all outputs 0; after release, no shift without a press.
2. Bounce rejection (DB_CNT=4): shift_btn_n low 2 cycles, high, low 3 cycles, high -> shift_reg stays 0 and match_cnt=0. A subsequent clean 10-cycle low press -> exactly one shift.
3. Pattern hit: press with din=1,0,1,1 -> after the 4th press shift_reg=8'h0B, last_bit=1, detect=1, match_cnt=1. After the 3rd press, detect=0.
4. Overlap: continue with presses din=0,1,1 -> after the 5th press detect=0; after the 7th press shift_reg=8'h5B, detect=1, match_cnt=2.
5. Long hold plus release bounce: hold the button low 200 cycles, then release with 2-cycle bounces -> exactly one shift; the FSM returns to S_IDLE only after DB_CNT stable high cycles.
6. Wrap and reset mid-press: produce 16 matches -> match_cnt=0 and detect=1. Then assert rst_n=0 while in S_DB_PRESS -> no shift and all outputs 0.

Source files
------------

// File: rtl/shift_pattern_detector.sv
// Serial bit shifter with button debounce, pattern match and match counter.
// Feeds the 1-bit and hex-digit display decoders.
module shift_pattern_detector #(
  parameter int                   PATTERN_W = 4,
  parameter logic [PATTERN_W-1:0] PATTERN   = 4'b1011,
  parameter int                   DB_CNT    = 1000000,
  parameter int                   CNT_W     = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             din,
  input  logic             shift_btn_n,
  output logic [7:0]       shift_reg,
  output logic             last_bit,
  output logic             detect,
  output logic [CNT_W-1:0] match_cnt
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DB_PRESS,
    S_HELD,
    S_DB_REL
  } state_t;

  localparam logic [19:0] DB_LAST = 20'(DB_CNT - 1);
  localparam logic [3:0]  PW4     = 4'(PATTERN_W);

  logic                 din_m;
  logic                 din_s;
  logic                 btn_m;
  logic                 btn_s;
  state_t               state;
  state_t               state_nxt;
  logic [19:0]          db;
  logic [19:0]          db_nxt;
  logic                 shift_pulse;
  logic [3:0]           valid_cnt;
  logic [3:0]           valid_inc;
  logic [PATTERN_W-1:0] nxt;
  logic                 hit;

  // Two-flop synchronisers; idle level is high for both inputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      din_m <= 1'b1;
      din_s <= 1'b1;
      btn_m <= 1'b1;
      btn_s <= 1'b1;
    end else begin
      din_m <= din;
      din_s <= din_m;
      btn_m <= shift_btn_n;
      btn_s <= btn_m;
    end
  end

  // Debounce state and stability counter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
      db    <= '0;
    end else begin
      state <= state_nxt;
      db    <= db_nxt;
    end
  end

  // Debounce transitions; one pulse per accepted press
  always_comb begin
    state_nxt   = state;
    db_nxt      = db;
    shift_pulse = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (!btn_s) begin
          state_nxt = S_DB_PRESS;
          db_nxt    = '0;
        end
      end
      S_DB_PRESS: begin
        if (btn_s) begin
          state_nxt = S_IDLE;
        end else if (db == DB_LAST) begin
          state_nxt   = S_HELD;
          shift_pulse = 1'b1;
        end else begin
          db_nxt = db + 20'd1;
        end
      end
      S_HELD: begin
        if (btn_s) begin
          state_nxt = S_DB_REL;
          db_nxt    = '0;
        end
      end
      S_DB_REL: begin
        if (!btn_s) begin
          state_nxt = S_HELD;
        end else if (db == DB_LAST) begin
          state_nxt = S_IDLE;
        end else begin
          db_nxt = db + 20'd1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign valid_inc = valid_cnt + 4'd1;
  assign nxt       = {shift_reg[PATTERN_W-2:0], din_s};
  assign hit       = (nxt == PATTERN) && (valid_inc >= PW4);

  // Shift, match level and match count all move on the pulse edge
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shift_reg <= '0;
      valid_cnt <= '0;
      detect    <= 1'b0;
      match_cnt <= '0;
    end else if (shift_pulse) begin
      shift_reg <= {shift_reg[6:0], din_s};
      valid_cnt <= (valid_cnt == 4'd8) ? 4'd8 : valid_inc;
      detect    <= hit;
      if (hit) begin
        match_cnt <= match_cnt + 1'b1;
      end
    end
  end

  assign last_bit = shift_reg[0];

endmodule

// File: tb/tb_shift_pattern_detector.sv
// Scoreboard bench for shift_pattern_detector with a bit-history model.
// Randomised press timing and data, bounce, long hold, wrap and reset cases.
module tb_shift_pattern_detector;

  localparam int         PW  = 4;
  localparam logic [3:0] PAT = 4'b1011;
  localparam int         DBC = 4;
  localparam int         CW  = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          din;
  logic          shift_btn_n;
  logic [7:0]    shift_reg;
  logic          last_bit;
  logic          detect;
  logic [CW-1:0] match_cnt;

  shift_pattern_detector #(
    .PATTERN_W(PW),
    .PATTERN  (PAT),
    .DB_CNT   (DBC),
    .CNT_W    (CW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .din        (din),
    .shift_btn_n(shift_btn_n),
    .shift_reg  (shift_reg),
    .last_bit   (last_bit),
    .detect     (detect),
    .match_cnt  (match_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         due;
    logic [7:0] r;
    logic       d;
    logic [3:0] c;
    string      tag;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: history of accepted bits since reset
  bit hist[$];
  int mcnt = 0;
  bit mdet = 0;

  function automatic logic [7:0] m_reg();
    logic [7:0] r;
    r = '0;
    for (int i = 0; i < 8; i++)
      if (i < hist.size()) r[i] = hist[hist.size()-1-i];
    return r;
  endfunction

  function automatic void m_press(bit b);
    logic [7:0] r;
    hist.push_back(b);
    r    = m_reg();
    mdet = (hist.size() >= PW) && (r[PW-1:0] == PAT);
    if (mdet) mcnt = (mcnt + 1) % (1 << CW);
  endfunction

  function automatic void m_reset();
    hist.delete();
    mcnt = 0;
    mdet = 0;
  endfunction

  function automatic void expect_at(int due, string tag);
    exp_t e;
    e.due = due;
    e.r   = m_reg();
    e.d   = mdet;
    e.c   = 4'(mcnt);
    e.tag = tag;
    sb.push_back(e);
  endfunction

  // Monitor: pop each expectation on its due cycle and compare
  always @(negedge clk) begin
    exp_t e;
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      e = sb.pop_front();
      checks++;
      if (e.due < cyc) begin
        errors++;
        $display("FAIL %s: check missed, due %0d now %0d", e.tag, e.due, cyc);
      end else if (shift_reg !== e.r || last_bit !== e.r[0] ||
                   detect !== e.d || match_cnt !== e.c) begin
        errors++;
        $display("FAIL %s @%0d: got reg=%h lb=%b det=%b cnt=%0d, want reg=%h lb=%b det=%b cnt=%0d",
                 e.tag, cyc, shift_reg, last_bit, detect, match_cnt,
                 e.r, e.r[0], e.d, e.c);
      end
    end
  end

  task automatic step(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset(int n);
    rst_n = 1'b0;
    m_reset();
    repeat (n) begin
      din         = 1'($urandom);
      shift_btn_n = 1'($urandom);
      step(1);
      expect_at(cyc, "reset_hold");
    end
    rst_n       = 1'b1;
    shift_btn_n = 1'b1;
    din         = 1'b0;
    step(5);
    expect_at(cyc, "post_reset_a");
    step(5);
    expect_at(cyc, "post_reset_b");
  endtask

  // Clean press: shift lands 7 edges after the raw falling edge
  task automatic press(bit b, int lo, int hi);
    int k;
    k           = cyc;
    din         = b;
    shift_btn_n = 1'b0;
    expect_at(k + 6, "pre_shift");
    m_press(b);
    expect_at(k + 7, "post_shift");
    step(lo);
    shift_btn_n = 1'b1;
    din         = 1'($urandom);
    expect_at(cyc + hi, "after_release");
    step(hi);
  endtask

  task automatic rpress(bit b);
    press(b, $urandom_range(6, 14), $urandom_range(10, 16));
  endtask

  initial begin
    bit seq[3];
    int n;
    rst_n       = 1'b0;
    din         = 1'b0;
    shift_btn_n = 1'b1;

    do_reset(3);

    shift_btn_n = 1'b0;
    step(2);
    shift_btn_n = 1'b1;
    step(1);
    shift_btn_n = 1'b0;
    step(3);
    shift_btn_n = 1'b1;
    step(12);
    expect_at(cyc, "bounce_reject");
    press(1'b1, 10, 12);

    do_reset(2);
    rpress(1'b1);
    rpress(1'b0);
    rpress(1'b1);
    rpress(1'b1);
    rpress(1'b0);
    rpress(1'b1);
    rpress(1'b1);

    begin
      int k;
      k           = cyc;
      din         = 1'b0;
      shift_btn_n = 1'b0;
      expect_at(k + 6, "hold_pre");
      m_press(1'b0);
      expect_at(k + 7, "hold_post");
      step(200);
      expect_at(cyc, "hold_end");
      for (int i = 0; i < 2; i++) begin
        shift_btn_n = 1'b1;
        step(2);
        shift_btn_n = 1'b0;
        step(2);
      end
      shift_btn_n = 1'b1;
      step(20);
      expect_at(cyc, "release_bounce");
    end

    seq[0] = 1'b1;
    seq[1] = 1'b1;
    seq[2] = 1'b0;
    n = 0;
    do begin
      rpress(seq[n % 3]);
      n++;
    end while (mcnt != 0 && n < 100);

    for (int i = 0; i < 30; i++) rpress(1'($urandom));

    begin
      din         = 1'b1;
      shift_btn_n = 1'b0;
      step(4);
      rst_n       = 1'b0;
      shift_btn_n = 1'b1;
      m_reset();
      step(1);
      expect_at(cyc, "midpress_rst_a");
      step(1);
      expect_at(cyc, "midpress_rst_b");
      rst_n = 1'b1;
      step(12);
      expect_at(cyc, "midpress_after");
    end

    for (int i = 0; i < 50 && sb.size() > 0; i++) step(1);
    if (sb.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations left, want 0", sb.size());
    end
    step(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
